// File: rtl/arb4_pkg.sv
// rtl/arb4_pkg.sv - shared types and helpers for the 4-way round-robin arbiter
package arb4_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [3:0] req_vec_t;

  // One-hot vector with bit idx set.
  function automatic req_vec_t onehot(input logic [SEL_W-1:0] idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating priority pick over four requests
//
// Ports:
//   req   - request vector, bit i = requester i
//   start - index scanned first; scan continues start+1 .. modulo 4
//   any   - high when at least one request bit is set
//   idx   - first requesting index found in scan order (start when any=0)
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = start;
    cand = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      // 2-bit addition wraps 3 -> 0 naturally.
      cand = start + 2'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4way.sv
// rtl/rr_arbiter4way.sv - round-robin arbiter with per-owner burst limit for Dmux4way
//
// Ports:
//   CLK    - system clock, rising edge
//   RST    - synchronous reset, active-high
//   REQ    - level request vector, held while the path is wanted
//   GNT    - registered one-hot grant, zero when idle
//   SEL    - registered selector index of the current owner (holds when idle)
//   BUSY   - high while a grant is active
//   SWITCH - one-cycle pulse in the first cycle of a new owner's grant
module rr_arbiter4way
  import arb4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
)
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] SEL,
  output logic       BUSY,
  output logic       SWITCH
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       hold_q, hold_d;
  req_vec_t         gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             switch_q, switch_d;

  req_vec_t         others;
  logic [SEL_W-1:0] hand_start;
  logic             idle_any, hand_any;
  logic [SEL_W-1:0] idle_idx, hand_idx;

  // While granted, sel_q is the current owner; handover scans from owner+1.
  assign others     = REQ & ~onehot(sel_q);
  assign hand_start = sel_q + 2'd1;

  rr_pick4 u_pick_idle (
    .req   (REQ),
    .start (ptr_q),
    .any   (idle_any),
    .idx   (idle_idx)
  );

  rr_pick4 u_pick_hand (
    .req   (others),
    .start (hand_start),
    .any   (hand_any),
    .idx   (hand_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    switch_d = 1'b0;

    if (state_q == IDLE) begin
      if (idle_any) begin
        state_d  = GRANT;
        gnt_d    = onehot(idle_idx);
        sel_d    = idle_idx;
        busy_d   = 1'b1;
        switch_d = 1'b1;
        hold_d   = 4'd1;
        ptr_d    = idle_idx + 2'd1;
      end
    end else begin
      if (REQ[sel_q] && (hold_q < HOLD_LIMIT)) begin
        hold_d = hold_q + 4'd1;
      end else if (hand_any) begin
        // Release or burst limit with someone waiting: hand over with no bubble.
        gnt_d    = onehot(hand_idx);
        sel_d    = hand_idx;
        switch_d = 1'b1;
        hold_d   = 4'd1;
        ptr_d    = hand_idx + 2'd1;
      end else if (!REQ[sel_q]) begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end else begin
        // Burst limit reached but nobody else wants the path: keep it.
        hold_d = 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      switch_q <= switch_d;
    end
  end

  assign GNT    = gnt_q;
  assign SEL    = sel_q;
  assign BUSY   = busy_q;
  assign SWITCH = switch_q;

endmodule

// File: tb/tb_rr_arbiter4way.sv
// tb/tb_rr_arbiter4way.sv - self-checking bench for rr_arbiter4way
module tb_rr_arbiter4way;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;

  logic [3:0] gnt    [3];
  logic [1:0] sel    [3];
  logic       busy   [3];
  logic       switch_o [3];

  int total = 0;
  int bad   = 0;

  // Reference state per instance: owner -1 means idle.
  int mh      [3] = '{4, 1, 3};
  int m_owner [3];
  int m_ptr   [3];
  int m_hold  [3];
  int m_sel   [3];
  int m_sw    [3];

  logic [3:0] req_s;
  logic       rst_s;
  int         wait_cnt [4];

  rr_arbiter4way #(.MAX_HOLD(4)) u_mh4 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt[0]), .SEL(sel[0]), .BUSY(busy[0]), .SWITCH(switch_o[0])
  );

  rr_arbiter4way #(.MAX_HOLD(1)) u_mh1 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt[1]), .SEL(sel[1]), .BUSY(busy[1]), .SWITCH(switch_o[1])
  );

  rr_arbiter4way #(.MAX_HOLD(3)) u_mh3 (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt[2]), .SEL(sel[2]), .BUSY(busy[2]), .SWITCH(switch_o[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic take(input int i, input int w);
    m_owner[i] = w;
    m_sel[i]   = w;
    m_sw[i]    = 1;
    m_hold[i]  = 1;
    m_ptr[i]   = (w + 1) % 4;
  endtask

  task automatic model_edge(input int i, input logic [3:0] r, input logic rst);
    int w;
    logic [3:0] oth;
    if (rst) begin
      m_owner[i] = -1; m_ptr[i] = 0; m_hold[i] = 0; m_sel[i] = 0; m_sw[i] = 0;
      return;
    end
    m_sw[i] = 0;
    if (m_owner[i] < 0) begin
      w = pick(r, m_ptr[i]);
      if (w >= 0) take(i, w);
    end else begin
      oth = r & ~(4'b0001 << m_owner[i]);
      if (r[m_owner[i]] && m_hold[i] < mh[i]) begin
        m_hold[i]++;
      end else begin
        w = pick(oth, (m_owner[i] + 1) % 4);
        if (w >= 0) take(i, w);
        else if (!r[m_owner[i]]) m_owner[i] = -1;
        else m_hold[i] = 1;
      end
    end
  endtask

  // One clock: advance the model on the edge, then compare just after it.
  task automatic step();
    logic [3:0] eg;
    @(posedge CLK);
    req_s = REQ;
    rst_s = RST;
    for (int i = 0; i < 3; i++) model_edge(i, req_s, rst_s);
    #1;
    for (int i = 0; i < 3; i++) begin
      eg = (m_owner[i] < 0) ? 4'b0000 : (4'b0001 << m_owner[i]);
      chk($sformatf("gnt_mh%0d", mh[i]), 32'(gnt[i]), 32'(eg));
      chk($sformatf("sel_mh%0d", mh[i]), 32'(sel[i]), 32'(m_sel[i]));
      chk($sformatf("busy_mh%0d", mh[i]), 32'(busy[i]), 32'(m_owner[i] >= 0));
      chk($sformatf("switch_mh%0d", mh[i]), 32'(switch_o[i]), 32'(m_sw[i]));
      chk($sformatf("onehot_mh%0d", mh[i]), 32'($countones(gnt[i]) <= 1), 32'd1);
      chk($sformatf("no_spurious_gnt_mh%0d", mh[i]), 32'(gnt[i] & ~req_s), 32'd0);
      if (busy[i] === 1'b1)
        chk($sformatf("sel_vs_gnt_mh%0d", mh[i]), 32'(gnt[i]), 32'(4'b0001 << sel[i]));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ = 4'b0000;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b0000;
    for (int r = 0; r < 4; r++) wait_cnt[r] = 0;
    #2;

    // Reset state.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", 32'(gnt[i]), 32'd0);
      chk("rst_sel", 32'(sel[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_switch", 32'(switch_o[i]), 32'd0);
    end

    // Two requesters alternate in MAX_HOLD=4 bursts.
    REQ = 4'b1010;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk("t1_gnt", 32'(gnt[0]), (((c - 1) / 4) % 2 == 1) ? 32'h8 : 32'h2);
      chk("t1_sel", 32'(sel[0]), (((c - 1) / 4) % 2 == 1) ? 32'd3 : 32'd1);
      chk("t1_switch", 32'(switch_o[0]), 32'(c == 1 || c == 5 || c == 9));
    end

    // Lone requester keeps the path across burst boundaries.
    do_reset();
    REQ = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("t2_gnt", 32'(gnt[0]), 32'h4);
      chk("t2_switch", 32'(switch_o[0]), 32'(c == 1));
    end
    REQ = 4'b0000;
    step();
    chk("t2_idle_gnt", 32'(gnt[0]), 32'd0);
    chk("t2_idle_busy", 32'(busy[0]), 32'd0);
    chk("t2_idle_sel_holds", 32'(sel[0]), 32'd2);

    // Owner releases with another pending: direct handover.
    do_reset();
    REQ = 4'b0011;
    step();
    chk("t3_c1_gnt", 32'(gnt[0]), 32'h1);
    step();
    chk("t3_c2_gnt", 32'(gnt[0]), 32'h1);
    chk("t3_c2_busy", 32'(busy[0]), 32'd1);
    REQ = 4'b0010;
    step();
    chk("t3_c3_gnt", 32'(gnt[0]), 32'h2);
    chk("t3_c3_sel", 32'(sel[0]), 32'd1);
    chk("t3_c3_switch", 32'(switch_o[0]), 32'd1);
    chk("t3_c3_busy", 32'(busy[0]), 32'd1);

    // Full contention, MAX_HOLD=1 rotates every cycle.
    do_reset();
    REQ = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk("t4_gnt", 32'(gnt[1]), 32'(4'b0001 << ((c - 1) % 4)));
      chk("t4_switch", 32'(switch_o[1]), 32'd1);
    end

    // Reset mid-grant restarts arbitration from pointer 0.
    do_reset();
    REQ = 4'b1001;
    for (int c = 1; c <= 5; c++) step();
    chk("t5_pre_gnt", 32'(gnt[0]), 32'h8);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5_rst_gnt", 32'(gnt[0]), 32'd0);
    chk("t5_rst_sel", 32'(sel[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    chk("t5_rst_switch", 32'(switch_o[0]), 32'd0);
    step();
    chk("t5_after_gnt", 32'(gnt[0]), 32'h1);
    chk("t5_after_switch", 32'(switch_o[0]), 32'd1);

    // Random traffic with fairness bound on the MAX_HOLD=3 instance.
    do_reset();
    REQ = 4'($urandom_range(0, 15));
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int r = 0; r < 4; r++) begin
        if (req_s[r] && !gnt[2][r]) wait_cnt[r]++;
        else wait_cnt[r] = 0;
        if (req_s[r])
          chk($sformatf("wait_bound_r%0d", r), 32'(wait_cnt[r] <= 3 * 3 + 1), 32'd1);
      end
      for (int r = 0; r < 4; r++) begin
        if ($urandom_range(0, 5) == 0) REQ[r] = ~REQ[r];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
